rob_sn_alloc: RTL and testbench
===============================

Name: rob_sn_alloc

Overview:
- Sequence-number allocator and requester arbiter for the reorder buffer.
- Grants one ROB slot per cycle among p_nreq dispatch requesters using round-robin priority, and hands the granted requester the next in-order sequence number (the ROB insert index).
- Tracks in-flight occupancy by counting retirements reported by the ROB dequeue-front completion, and back-pressures all requesters when every slot is allocated.

Parameters:
- p_depth, 32, number of ROB slots; must be a power of two, at least 2.
- p_ptrwidth, $clog2(p_depth), sequence-number width.
- p_nreq, 4, number of requesters, 2..8.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- req  input  p_nreq  per-requester allocation request (bit i = requester i)
- gnt  output  p_nreq  one-hot grant; allocation happens in any cycle where gnt is nonzero
- alloc_sn  output  p_ptrwidth  sequence number handed to the granted requester, valid when |gnt
- retire  input  1  one slot freed this cycle; driven by the ROB dequeue-front completion
- count  output  p_ptrwidth+1  slots currently allocated, 0..p_depth
- full  output  1  count == p_depth
- empty  output  1  count == 0
- err_underflow  output  1  sticky; set when retire arrives while count == 0

Behaviour:
- State registers:
  - alloc_ptr, p_ptrwidth bits
  - cnt, p_ptrwidth+1 bits
  - prio, $clog2(p_nreq) bits, the highest-priority requester index
  - err, 1 bit
- Reset: all state registers cleared to 0. While rst is high, combinationally gnt = 0, alloc_sn = 0, count = 0, full = 0, empty = 1 and err_underflow = 0. Reset asserted mid-operation discards all allocations with no drain.
- Grant is combinational, zero latency:
  - If full == 0 and req != 0, exactly one gnt bit is asserted: the first requester with req set, searching i = prio, prio+1, ... and wrapping modulo p_nreq.
  - If full == 1, gnt = 0 regardless of req.
- alloc_sn = alloc_ptr combinationally; it does not depend on which requester wins.
- Updates on the rising edge with a grant:
  - alloc_ptr <= alloc_ptr + 1, wrapping p_depth-1 -> 0 at natural p_ptrwidth width.
  - prio <= (granted index + 1) mod p_nreq.
- No grant: alloc_ptr and prio hold, so an idle requester never gains priority.
- cnt update per cycle, where g = |gnt and r = retire accepted:
  - g only: +1
  - r only: -1
  - both: unchanged
  - neither: hold
- Retire acceptance:
  - Retire is accepted when cnt > 0.
  - When cnt == 0, retire is ignored, cnt stays 0 and err is set. err clears only on rst.
- Full boundary: a retire arriving while full does not enable a same-cycle grant, because full is registered-state based. The freed slot becomes grantable on the next cycle. This is decided, so that no combinational path exists from retire to gnt.
- Empty boundary: a grant and a retire are not both possible from cnt == 0 (the retire is rejected). The result is cnt = 1 and err set.
- Requester contract: a requester holds req until it sees its gnt bit. Deasserting req before grant is legal and drops the request with no side effects.
- Sequence numbers are issued strictly in order with no gaps. The ROB dequeue pointer therefore tracks alloc_ptr - cnt modulo p_depth.
- count, full, empty and err_underflow are driven directly from the registers, outside of reset.

Test Plan:
- Reset then idle: rst high 2 cycles, then req = 0 for 3 cycles -> gnt = 0, alloc_sn = 0, count = 0, empty = 1, full = 0, err_underflow = 0 throughout.
- Round-robin: p_nreq = 4, req = 4'b1111 held 8 cycles, no retire -> gnt sequence 0001, 0010, 0100, 1000, 0001, ...; alloc_sn 0..7; count 8 after the last edge.
- Fairness with skip: prio = 0, req = 4'b1010 -> gnt = 0010; next cycle req = 4'b1011 -> gnt = 1000; next cycle -> gnt = 0001.
- Full and wrap: p_depth = 32, grant 32 times -> full = 1 and gnt = 0 with req held. Assert retire 1 cycle -> gnt still 0 that cycle, count = 31 after the edge, gnt asserted next cycle with alloc_sn = 0 (wrapped), count back to 32.
- Simultaneous grant + retire at count = 5 -> count stays 5, alloc_sn advances by 1.
- Underflow: from reset, retire = 1 for 1 cycle -> count stays 0, err_underflow = 1 and remains 1 until rst.

Source files
------------

// File: rtl/rob_sn_alloc_if.sv
// Dispatch-side bus of the ROB sequence-number allocator.
// The master side drives requests and retirements; the slave side returns grants and occupancy.
interface rob_sn_alloc_if #(
   parameter int p_nreq     = 4,
   parameter int p_ptrwidth = 5
);
   logic [p_nreq-1:0]     req;
   logic [p_nreq-1:0]     gnt;
   logic [p_ptrwidth-1:0] alloc_sn;
   logic                  retire;
   logic [p_ptrwidth:0]   count;
   logic                  full;
   logic                  empty;
   logic                  err_underflow;

   modport master (
      output req, retire,
      input  gnt, alloc_sn, count, full, empty, err_underflow
   );

   modport slave (
      input  req, retire,
      output gnt, alloc_sn, count, full, empty, err_underflow
   );
endinterface

// File: rtl/rob_sn_alloc.sv
// ROB sequence-number allocator: round-robin grant of one slot per cycle,
// in-order sequence numbers, occupancy tracking and a sticky underflow flag.
module rob_sn_alloc #(
   parameter int p_depth    = 32,
   parameter int p_ptrwidth = $clog2(p_depth),
   parameter int p_nreq     = 4
) (
   input logic          clk,
   input logic          rst,
   rob_sn_alloc_if.slave bus
);
   localparam int p_priow = $clog2(p_nreq);

   logic [p_ptrwidth-1:0] r_alloc_ptr;
   logic [p_ptrwidth:0]   r_cnt;
   logic [p_priow-1:0]    r_prio;
   logic                  r_err;

   logic [p_nreq-1:0]     w_gnt;
   logic [p_priow-1:0]    w_gidx;
   logic [p_priow-1:0]    w_prio_nxt;
   logic [p_priow:0]      w_sum;
   logic [p_priow-1:0]    w_cand;
   logic                  w_full;
   logic                  w_grant;
   logic                  w_ret_ok;

   // full comes from registered count only, so retire never reaches gnt combinationally
   assign w_full   = (r_cnt == (p_ptrwidth+1)'(p_depth));
   assign w_ret_ok = bus.retire && (r_cnt != '0);

   always_comb begin
      w_gnt   = '0;
      w_gidx  = '0;
      w_grant = 1'b0;
      w_sum   = '0;
      w_cand  = '0;
      for (int unsigned k = 0; k < p_nreq; k++) begin
         w_sum = {1'b0, r_prio} + (p_priow+1)'(k);
         if (w_sum >= (p_priow+1)'(p_nreq))
            w_sum = w_sum - (p_priow+1)'(p_nreq);
         w_cand = w_sum[p_priow-1:0];
         if (!w_grant && bus.req[w_cand]) begin
            w_grant       = 1'b1;
            w_gidx        = w_cand;
            w_gnt[w_cand] = 1'b1;
         end
      end
      if (w_full || rst) begin
         w_gnt   = '0;
         w_grant = 1'b0;
      end
   end

   assign w_prio_nxt = (w_gidx == p_priow'(p_nreq - 1)) ? '0 : w_gidx + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_alloc_ptr <= '0;
         r_cnt       <= '0;
         r_prio      <= '0;
         r_err       <= 1'b0;
      end else begin
         if (w_grant) begin
            r_alloc_ptr <= r_alloc_ptr + 1'b1;
            r_prio      <= w_prio_nxt;
         end
         case ({w_grant, w_ret_ok})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
         if (bus.retire && (r_cnt == '0))
            r_err <= 1'b1;
      end
   end

   assign bus.gnt           = w_gnt;
   assign bus.alloc_sn      = rst ? '0 : r_alloc_ptr;
   assign bus.count         = rst ? '0 : r_cnt;
   assign bus.full          = !rst && w_full;
   assign bus.empty         = rst || (r_cnt == '0);
   assign bus.err_underflow = !rst && r_err;
endmodule

// File: tb/tb_rob_sn_alloc.sv
// Directed bench for rob_sn_alloc: reference model plus a queue of expected
// sequence numbers, pushed when a grant is predicted and popped when one appears.
module tb_rob_sn_alloc;
   logic clk;
   logic rst;

   rob_sn_alloc_if #(.p_nreq(4), .p_ptrwidth(5)) bif ();

   rob_sn_alloc #(.p_depth(32), .p_ptrwidth(5), .p_nreq(4)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned nvec  = 0;
   int unsigned nfail = 0;

   int         m_cnt;
   int         m_prio;
   logic [4:0] m_ptr;
   logic       m_err;
   logic [4:0] sbq[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input logic rs, input logic [3:0] rq, input logic rt,
                      output logic [3:0] og, output logic [4:0] osn,
                      output logic [5:0] ocnt, output logic oerr);
      logic [3:0] eg;
      logic [4:0] sn;
      int gi;
      int rok;
      @(negedge clk);
      rst        = rs;
      bif.req    = rq;
      bif.retire = rt;
      #1;
      eg = '0;
      gi = -1;
      if (!rs && m_cnt != 32) begin
         for (int k = 0; k < 4; k++) begin
            int j;
            j = (m_prio + k) % 4;
            if (gi < 0 && rq[j]) gi = j;
         end
      end
      if (gi >= 0) begin
         eg[gi] = 1'b1;
         sbq.push_back(m_ptr);
      end
      og   = bif.gnt;
      osn  = bif.alloc_sn;
      ocnt = bif.count;
      oerr = bif.err_underflow;
      chk("gnt",   32'(bif.gnt), 32'(eg));
      chk("count", 32'(bif.count), rs ? 32'd0 : 32'(m_cnt));
      chk("full",  32'(bif.full), (!rs && m_cnt == 32) ? 32'd1 : 32'd0);
      chk("empty", 32'(bif.empty), (rs || m_cnt == 0) ? 32'd1 : 32'd0);
      chk("err",   32'(bif.err_underflow), rs ? 32'd0 : 32'(m_err));
      if (rs) chk("sn_rst", 32'(bif.alloc_sn), 32'd0);
      if (|bif.gnt) begin
         nvec++;
         assert (sbq.size() != 0) else begin
            nfail++;
            $error("FAIL sn_queue observed=grant expected=no_grant");
         end
         if (sbq.size() != 0) begin
            sn = sbq.pop_front();
            chk("alloc_sn", 32'(bif.alloc_sn), 32'(sn));
         end
      end
      sbq.delete();
      @(posedge clk);
      if (rs) begin
         m_cnt = 0; m_prio = 0; m_ptr = '0; m_err = 1'b0;
      end else begin
         rok = (rt && m_cnt != 0) ? 1 : 0;
         if (rt && m_cnt == 0) m_err = 1'b1;
         if (gi >= 0) begin
            m_ptr  = m_ptr + 5'd1;
            m_prio = (gi + 1) % 4;
         end
         m_cnt = m_cnt + ((gi >= 0) ? 1 : 0) - rok;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] og;
      logic [4:0] osn;
      logic [5:0] ocnt;
      logic       oerr;
      logic [3:0] rrtab [8];
      rrtab = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
      m_cnt = 0; m_prio = 0; m_ptr = '0; m_err = 1'b0;
      rst = 1'b1; bif.req = '0; bif.retire = 1'b0;

      // reset then idle
      repeat (2) cyc(1'b1, 4'b0000, 1'b0, og, osn, ocnt, oerr);
      repeat (3) begin
         cyc(1'b0, 4'b0000, 1'b0, og, osn, ocnt, oerr);
         chk("idle_sn", 32'(osn), 32'd0);
      end

      // round robin, all requesting
      for (int i = 0; i < 8; i++) begin
         cyc(1'b0, 4'b1111, 1'b0, og, osn, ocnt, oerr);
         chk("rr_gnt", 32'(og), 32'(rrtab[i]));
         chk("rr_sn", 32'(osn), 32'(i));
      end

      // fairness with skipped requesters, prio back at 0
      cyc(1'b0, 4'b1010, 1'b0, og, osn, ocnt, oerr);
      chk("rr_count8", 32'(ocnt), 32'd8);
      chk("fair0", 32'(og), 32'b0010);
      cyc(1'b0, 4'b1011, 1'b0, og, osn, ocnt, oerr);
      chk("fair1", 32'(og), 32'b1000);
      cyc(1'b0, 4'b1011, 1'b0, og, osn, ocnt, oerr);
      chk("fair2", 32'(og), 32'b0001);

      // fill to 32
      repeat (21) cyc(1'b0, 4'b1111, 1'b0, og, osn, ocnt, oerr);
      cyc(1'b0, 4'b1111, 1'b0, og, osn, ocnt, oerr);
      chk("full_gnt", 32'(og), 32'd0);
      chk("full_cnt", 32'(ocnt), 32'd32);
      cyc(1'b0, 4'b1111, 1'b1, og, osn, ocnt, oerr);
      chk("full_ret_gnt", 32'(og), 32'd0);
      cyc(1'b0, 4'b1111, 1'b0, og, osn, ocnt, oerr);
      chk("wrap_gnt", 32'(|og), 32'd1);
      chk("wrap_sn", 32'(osn), 32'd0);
      chk("wrap_cnt31", 32'(ocnt), 32'd31);
      cyc(1'b0, 4'b0000, 1'b0, og, osn, ocnt, oerr);
      chk("wrap_cnt32", 32'(ocnt), 32'd32);

      // reset mid-operation discards everything
      cyc(1'b1, 4'b1111, 1'b0, og, osn, ocnt, oerr);
      chk("midrst_gnt", 32'(og), 32'd0);
      cyc(1'b0, 4'b0000, 1'b0, og, osn, ocnt, oerr);
      chk("midrst_cnt", 32'(ocnt), 32'd0);

      // simultaneous grant and retire at count 5
      repeat (5) cyc(1'b0, 4'b0001, 1'b0, og, osn, ocnt, oerr);
      cyc(1'b0, 4'b0001, 1'b1, og, osn, ocnt, oerr);
      chk("both_sn", 32'(osn), 32'd5);
      chk("both_cnt_before", 32'(ocnt), 32'd5);
      cyc(1'b0, 4'b0000, 1'b0, og, osn, ocnt, oerr);
      chk("both_cnt", 32'(ocnt), 32'd5);
      chk("both_sn_next", 32'(osn), 32'd6);

      // underflow is sticky until reset
      cyc(1'b1, 4'b0000, 1'b0, og, osn, ocnt, oerr);
      cyc(1'b0, 4'b0000, 1'b1, og, osn, ocnt, oerr);
      chk("uf_err_pre", 32'(oerr), 32'd0);
      repeat (3) begin
         cyc(1'b0, 4'b0000, 1'b0, og, osn, ocnt, oerr);
         chk("uf_err", 32'(oerr), 32'd1);
         chk("uf_cnt", 32'(ocnt), 32'd0);
      end
      cyc(1'b1, 4'b0000, 1'b0, og, osn, ocnt, oerr);
      cyc(1'b0, 4'b0000, 1'b0, og, osn, ocnt, oerr);
      chk("uf_cleared", 32'(oerr), 32'd0);

      // grant plus rejected retire from empty
      cyc(1'b0, 4'b0100, 1'b1, og, osn, ocnt, oerr);
      chk("empty_both_gnt", 32'(og), 32'b0100);
      cyc(1'b0, 4'b0000, 1'b0, og, osn, ocnt, oerr);
      chk("empty_both_cnt", 32'(ocnt), 32'd1);
      chk("empty_both_err", 32'(oerr), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end
endmodule
